// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_bist self-test block: FSM states, LFSR
// polynomial, default seed and the LFSR step/seed helpers.
package pipe_pkg;

    localparam int          DATA_W       = 8;
    // Feedback taps of x^32 + x^22 + x^2 + x + 1 (the x^32 term is implicit).
    localparam logic [31:0] LFSR_POLY    = 32'h0040_0007;
    localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2345;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

endpackage

// File: rtl/pipe_bist_if.sv
// Bus between pipe_bist and its user: operands out, result back, status out.
// master = the BIST engine, slave = the datapath under test / controller side.
interface pipe_bist_if;
    import pipe_pkg::*;

    logic              start;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [7:0]        err_count;
    logic [7:0]        first_err_idx;

    modport master (
        input  start, dut_out,
        output a, b, c, d, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        output start, dut_out,
        input  a, b, c, d, busy, done, pass, err_count, first_err_idx
    );

endinterface

// File: rtl/pipe_ref_model.sv
// Golden ((a+b)*(c-d)) mod 256 plus a LATENCY-deep delay line carrying the
// expected value, valid bit and (with PIPE_BIST_ERRLOG_EN) the vector index.
module pipe_ref_model
    import pipe_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    input  logic [DATA_W-1:0] d_i,
`ifdef PIPE_BIST_ERRLOG_EN
    input  logic [7:0]        idx_i,
    output logic [7:0]        idx_o,
`endif
    output logic              vld_o,
    output logic [DATA_W-1:0] exp_o
);

    function automatic logic [DATA_W-1:0] exp_calc(
        input logic [DATA_W-1:0] a, b, c, d
    );
        logic [DATA_W-1:0]   sum;
        logic [DATA_W-1:0]   dif;
        logic [2*DATA_W-1:0] prod;
        sum  = a + b;
        dif  = c - d;
        prod = sum * dif;
        return prod[DATA_W-1:0];
    endfunction

    logic [LATENCY-1:0] vld_q;
    logic [DATA_W-1:0]  exp_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= vld_i;
            for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    // Data stages carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        exp_q[0] <= exp_calc(a_i, b_i, c_i, d_i);
        for (int i = 1; i < LATENCY; i++) exp_q[i] <= exp_q[i-1];
    end

    assign vld_o = vld_q[LATENCY-1];
    assign exp_o = exp_q[LATENCY-1];

`ifdef PIPE_BIST_ERRLOG_EN
    logic [7:0] idx_q [LATENCY];

    always_ff @(posedge clk) begin
        idx_q[0] <= idx_i;
        for (int i = 1; i < LATENCY; i++) idx_q[i] <= idx_q[i-1];
    end

    assign idx_o = idx_q[LATENCY-1];
`endif

endmodule

// File: rtl/pipe_bist.sv
// Built-in self test for a 4-operand datapath: LFSR stimulus, delayed golden
// compare, saturating error count. PIPE_BIST_ERRLOG_EN adds first-error capture.
module pipe_bist
    import pipe_pkg::*;
#(
    parameter int          LATENCY     = 3,
    parameter int          NUM_VECTORS = 16,
    parameter logic [31:0] SEED        = DEFAULT_SEED
) (
    input  logic      clk,
    input  logic      rst_n,
    pipe_bist_if.master bus
);

    localparam logic [31:0] SEED_EFF   = seed_fix(SEED);
    localparam logic [7:0]  LAST_IDX   = 8'(NUM_VECTORS - 1);
    localparam logic [3:0]  LAST_DRAIN = 4'(LATENCY - 1);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t            state_q, state_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [7:0]        idx_q, idx_d;
    logic [3:0]        drain_q, drain_d;
    logic [7:0]        err_q, err_d;
    logic              issue;
    logic              start_ok;
    logic              ref_vld;
    logic [DATA_W-1:0] ref_exp;
    logic              mismatch;

    assign issue    = (state_q == ST_RUN);
    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);

    // Operands come straight from the registered LFSR, forced to zero outside RUN.
    assign bus.a = issue ? lfsr_q[31:24] : '0;
    assign bus.b = issue ? lfsr_q[23:16] : '0;
    assign bus.c = issue ? lfsr_q[15:8]  : '0;
    assign bus.d = issue ? lfsr_q[7:0]   : '0;

`ifdef PIPE_BIST_ERRLOG_EN
    logic [7:0] ref_idx;
`endif

    pipe_ref_model #(
        .LATENCY (LATENCY)
    ) u_ref (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (issue),
        .a_i   (bus.a),
        .b_i   (bus.b),
        .c_i   (bus.c),
        .d_i   (bus.d),
`ifdef PIPE_BIST_ERRLOG_EN
        .idx_i (idx_q),
        .idx_o (ref_idx),
`endif
        .vld_o (ref_vld),
        .exp_o (ref_exp)
    );

    assign mismatch = ref_vld && (bus.dut_out != ref_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lfsr_q  <= SEED_EFF;
            idx_q   <= '0;
            drain_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            drain_q <= drain_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        err_d   = mismatch ? sat_inc(err_q) : err_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // The LFSR is deliberately not reseeded: each run continues the sequence.
                if (bus.start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                    err_d   = '0;
                end
            end
            ST_RUN: begin
                lfsr_d = lfsr_step(lfsr_q);
                idx_d  = idx_q + 8'd1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 4'd1;
                if (drain_q == LAST_DRAIN) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.pass      = (state_q == ST_DONE) && (err_q == 8'd0);
    assign bus.err_count = err_q;

`ifdef PIPE_BIST_ERRLOG_EN
    logic [7:0] fei_q, fei_d;

    // err_q == 0 marks the first mismatch of the run, since start clears both.
    always_comb begin
        fei_d = fei_q;
        if (start_ok)                     fei_d = 8'hFF;
        else if (mismatch && err_q == '0) fei_d = ref_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fei_q <= 8'hFF;
        else        fei_q <= fei_d;
    end

    assign bus.first_err_idx = fei_q;
`else
    assign bus.first_err_idx = 8'hFF;
`endif

endmodule
